// File: rtl/regsel_hazard_ctrl_if.sv
// regsel_hazard_ctrl_if: issue-side bundle of the register-select controller.
//   master : decode stage (drives instruction fields, stall_in, flush)
//   slave  : regsel_hazard_ctrl (drives asel/bsel/dsel, hazard, issued)
interface regsel_hazard_ctrl_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
);
  logic                in_valid;
  logic                r_type;
  logic                i_type;
  logic                d_type;
  logic                is_store;
  logic                cb_type;
  logic                reg_write;
  logic [ADDR_W-1:0]   rn;
  logic [ADDR_W-1:0]   rm;
  logic [ADDR_W-1:0]   rd;
  logic                stall_in;
  logic                flush;
  logic [NUM_REGS-1:0] asel;
  logic [NUM_REGS-1:0] bsel;
  logic [NUM_REGS-1:0] dsel;
  logic                hazard;
  logic                issued;

  modport master (
    output in_valid, r_type, i_type, d_type, is_store, cb_type, reg_write,
    output rn, rm, rd, stall_in, flush,
    input  asel, bsel, dsel, hazard, issued
  );

  modport slave (
    input  in_valid, r_type, i_type, d_type, is_store, cb_type, reg_write,
    input  rn, rm, rd, stall_in, flush,
    output asel, bsel, dsel, hazard, issued
  );
endinterface

// File: rtl/regsel_hazard_ctrl.sv
// regsel_hazard_ctrl: pipelined LEGv8 register-file select controller.
// Decodes rn/rm/rd into registered one-hot read selects (asel, bsel), carries
// destinations down a WB_DEPTH-deep pipe to produce the one-hot write select
// (dsel), and raises a combinational RAW hazard against in-flight writes.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : regsel_hazard_ctrl_if.slave (instruction fields, stall_in, flush,
//           asel/bsel/dsel, hazard, issued)
// Optional build macro REGSEL_ZERO_REG_EN: register NUM_REGS-1 (XZR) is never
// written and never causes a hazard; reads of it still select normally.
module regsel_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int WB_DEPTH = 3
) (
  input logic                 clk,
  input logic                 reset,
  regsel_hazard_ctrl_if.slave bus
);

`ifdef REGSEL_ZERO_REG_EN
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);
`endif

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] i);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Destination pipe: entry 0 is the youngest, WB_DEPTH-1 is at writeback.
  logic [WB_DEPTH-1:0]             vld_pipe_q, vld_pipe_d;
  logic [WB_DEPTH-1:0][ADDR_W-1:0] idx_pipe_q, idx_pipe_d;
  logic [NUM_REGS-1:0]             asel_q, asel_d, bsel_q, bsel_d;
  logic                            issued_q, issued_d;

  logic              a_used, b_used, haz_a, haz_b, hazard, issue, wr_valid;
  logic [ADDR_W-1:0] b_idx;

  assign a_used = bus.r_type | bus.i_type | bus.d_type;
  assign b_used = bus.r_type | (bus.d_type & bus.is_store) | bus.cb_type;
  assign b_idx  = bus.r_type ? bus.rm : bus.rd;

  // Writeback slot is not compared: the file writes in the first half-cycle,
  // so a read in the same cycle already sees the new value.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = 0; k < WB_DEPTH - 1; k++) begin
      if (vld_pipe_q[k]) begin
        if (idx_pipe_q[k] == bus.rn) haz_a = 1'b1;
        if (idx_pipe_q[k] == b_idx)  haz_b = 1'b1;
      end
    end
`ifdef REGSEL_ZERO_REG_EN
    if (bus.rn == XZR) haz_a = 1'b0;
    if (b_idx  == XZR) haz_b = 1'b0;
`endif
  end

  assign hazard = bus.in_valid & ((a_used & haz_a) | (b_used & haz_b));
  assign issue  = bus.in_valid & ~hazard & ~bus.stall_in & ~bus.flush;

`ifdef REGSEL_ZERO_REG_EN
  assign wr_valid = issue & bus.reg_write & (bus.rd != XZR);
`else
  assign wr_valid = issue & bus.reg_write;
`endif

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    idx_pipe_d = idx_pipe_q;
    asel_d     = asel_q;
    bsel_d     = bsel_q;
    issued_d   = issued_q;
    if (bus.flush) begin
      // Entry WB_DEPTH-1 commits this cycle; everything younger is squashed,
      // so nothing valid remains after the shift.
      vld_pipe_d = '0;
      idx_pipe_d = {idx_pipe_q[WB_DEPTH-2:0], bus.rd};
      asel_d     = '0;
      bsel_d     = '0;
      issued_d   = 1'b0;
    end else if (!bus.stall_in) begin
      // Hazard or idle cycles shift in a bubble (wr_valid low).
      vld_pipe_d = {vld_pipe_q[WB_DEPTH-2:0], wr_valid};
      idx_pipe_d = {idx_pipe_q[WB_DEPTH-2:0], bus.rd};
      asel_d     = (issue && a_used) ? onehot(bus.rn) : '0;
      bsel_d     = (issue && b_used) ? onehot(b_idx)  : '0;
      issued_d   = issue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      asel_q     <= '0;
      bsel_q     <= '0;
      issued_q   <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      issued_q   <= issued_d;
    end
  end

  // A stalled entry stays put and must not write twice; a flush still shifts
  // the writeback entry out, so it commits even if stall_in is also high.
  assign bus.dsel   = (vld_pipe_q[WB_DEPTH-1] && (!bus.stall_in || bus.flush))
                      ? onehot(idx_pipe_q[WB_DEPTH-1]) : '0;
  assign bus.asel   = asel_q;
  assign bus.bsel   = bsel_q;
  assign bus.issued = issued_q;
  assign bus.hazard = hazard;

endmodule

// File: tb/tb_regsel_hazard_ctrl.sv
// Directed bench for regsel_hazard_ctrl. Expected outputs are queued with the
// cycle they are due when stimulus is driven, and checked at the falling edge.
module tb_regsel_hazard_ctrl;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int WB = 3;

  localparam int S_ASEL = 0;
  localparam int S_BSEL = 1;
  localparam int S_DSEL = 2;
  localparam int S_HAZ  = 3;
  localparam int S_ISS  = 4;

  typedef struct {
    int            cyc;
    int            sig;
    logic [NR-1:0] val;
    string         tag;
  } exp_t;

  logic clk;
  logic reset;
  regsel_hazard_ctrl_if #(.NUM_REGS(NR), .ADDR_W(AW)) bus ();

  regsel_hazard_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .WB_DEPTH(WB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  task automatic expect_at(input int dc, input int sig, input logic [NR-1:0] v,
                           input string tag);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare everything due this cycle, then advance to just after the next edge.
  task automatic next_cycle();
    logic [NR-1:0] o;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].sig)
          S_ASEL:  o = bus.asel;
          S_BSEL:  o = bus.bsel;
          S_DSEL:  o = bus.dsel;
          S_HAZ:   o = NR'(bus.hazard);
          default: o = NR'(bus.issued);
        endcase
        checks++;
        assert (o === sb[i].val) passed++;
        else $error("FAIL %s cyc=%0d: got %h expected %h", sb[i].tag, cyc, o, sb[i].val);
        sb.delete(i);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit v, input bit r, input bit i, input bit d,
                       input bit st, input bit cb, input bit wr,
                       input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                       input logic [AW-1:0] rd);
    bus.in_valid  = v;
    bus.r_type    = r;
    bus.i_type    = i;
    bus.d_type    = d;
    bus.is_store  = st;
    bus.cb_type   = cb;
    bus.reg_write = wr;
    bus.rn        = rn;
    bus.rm        = rm;
    bus.rd        = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    expect_at(0, S_ASEL, '0, "rst_asel");
    expect_at(0, S_BSEL, '0, "rst_bsel");
    expect_at(0, S_DSEL, '0, "rst_dsel");
    expect_at(0, S_HAZ,  '0, "rst_haz");
    expect_at(0, S_ISS,  '0, "rst_iss");
    next_cycle();
    reset = 1'b0;

    // 1: R-type rn=1 rm=2 rd=3
    drive(1, 1, 0, 0, 0, 0, 1, 1, 2, 3);
    expect_at(0,    S_HAZ,  '0,    "t1_haz");
    expect_at(1,    S_ISS,  1,     "t1_iss");
    expect_at(1,    S_ASEL, 'h2,   "t1_asel");
    expect_at(1,    S_BSEL, 'h4,   "t1_bsel");
    expect_at(2,    S_ISS,  0,     "t1_iss_end");
    expect_at(WB-1, S_DSEL, '0,    "t1_dsel_early");
    expect_at(WB,   S_DSEL, 'h8,   "t1_dsel");
    expect_at(WB+1, S_DSEL, '0,    "t1_dsel_once");
    next_cycle();
    idle();
    repeat (WB + 1) next_cycle();

    // 2: write X5, then I-type reading X5
    drive(1, 1, 0, 0, 0, 0, 1, 1, 2, 5);
    expect_at(0, S_HAZ, '0, "t2_haz_first");
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 5, 0, 0);
    for (int k = 0; k < WB - 1; k++) begin
      expect_at(k,     S_HAZ,  1,  "t2_haz");
      expect_at(k + 1, S_ASEL, '0, "t2_bubble_asel");
      expect_at(k + 1, S_ISS,  0,  "t2_bubble_iss");
    end
    expect_at(WB-1, S_HAZ,  '0,    "t2_haz_clear");
    expect_at(WB-1, S_DSEL, 'h20,  "t2_dsel");
    expect_at(WB,   S_ASEL, 'h20,  "t2_asel");
    expect_at(WB,   S_BSEL, '0,    "t2_bsel");
    expect_at(WB,   S_ISS,  1,     "t2_iss");
    repeat (WB) next_cycle();
    idle();
    repeat (2) next_cycle();

    // 3: D-type store rn=4 rd=7, then CB rd=9
    drive(1, 0, 0, 1, 1, 0, 0, 4, 0, 7);
    expect_at(0,  S_HAZ,  '0,    "t3_haz");
    expect_at(1,  S_ASEL, 'h10,  "t3_st_asel");
    expect_at(1,  S_BSEL, 'h80,  "t3_st_bsel");
    expect_at(WB, S_DSEL, '0,    "t3_st_nodsel");
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 9);
    expect_at(1,  S_ASEL, '0,    "t3_cb_asel");
    expect_at(1,  S_BSEL, 'h200, "t3_cb_bsel");
    expect_at(1,  S_ISS,  1,     "t3_cb_iss");
    next_cycle();
    idle();
    repeat (WB + 1) next_cycle();

    // 4: write X6, stall 3 cycles while a dependent read waits
    drive(1, 1, 0, 0, 0, 0, 1, 1, 2, 6);
    expect_at(0, S_HAZ, '0, "t4_haz_first");
    for (int j = 1; j <= 4; j++) begin
      expect_at(j, S_ASEL, 'h2, "t4_hold_asel");
      expect_at(j, S_ISS,  1,   "t4_hold_iss");
    end
    for (int j = 1; j <= WB + 2; j++) begin
      expect_at(j, S_DSEL, '0, "t4_dsel_quiet");
      expect_at(j, S_HAZ,  1,  "t4_haz");
    end
    expect_at(WB+3, S_DSEL, 'h40, "t4_dsel");
    expect_at(WB+3, S_HAZ,  '0,   "t4_haz_clear");
    expect_at(WB+4, S_DSEL, '0,   "t4_dsel_once");
    expect_at(WB+4, S_ASEL, 'h40, "t4_asel");
    expect_at(WB+4, S_ISS,  1,    "t4_iss");
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 6, 0, 0);
    bus.stall_in = 1'b1;
    repeat (3) next_cycle();
    bus.stall_in = 1'b0;
    repeat (WB) next_cycle();
    idle();
    repeat (2) next_cycle();

    // 5: X1 at writeback, X2 in p[0], flush
    drive(1, 1, 0, 0, 0, 0, 1, 3, 4, 1);
    expect_at(WB,   S_DSEL, 'h2, "t5_dsel_x1");
    expect_at(WB,   S_HAZ,  1,   "t5_haz_x2");
    expect_at(WB+1, S_HAZ,  '0,  "t5_haz_flushed");
    expect_at(WB+1, S_ASEL, '0,  "t5_flush_asel");
    expect_at(WB+1, S_ISS,  0,   "t5_flush_iss");
    expect_at(WB+2, S_ASEL, 'h4, "t5_reissue_asel");
    for (int j = WB + 1; j <= 2 * WB + 1; j++)
      expect_at(j, S_DSEL, '0, "t5_no_x2_write");
    next_cycle();
    for (int k = 1; k < WB; k++) begin
      if (k == WB - 1) drive(1, 0, 1, 0, 0, 0, 1, 0, 0, 2);
      else idle();
      next_cycle();
    end
    drive(1, 0, 1, 0, 0, 0, 0, 2, 0, 0);
    bus.flush = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    next_cycle();
    idle();
    repeat (WB + 1) next_cycle();

    // 6: write X31 then read X31
    drive(1, 0, 1, 0, 0, 0, 1, 0, 0, 31);
    expect_at(0, S_HAZ, '0, "t6_haz_first");
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 31, 0, 0);
`ifdef REGSEL_ZERO_REG_EN
    expect_at(0, S_HAZ,  '0,           "t6_xzr_nohaz");
    expect_at(1, S_ASEL, 'h80000000,   "t6_xzr_asel");
    expect_at(1, S_ISS,  1,            "t6_xzr_iss");
    for (int j = 0; j <= WB; j++)
      expect_at(j, S_DSEL, '0, "t6_xzr_nodsel");
    next_cycle();
    idle();
    repeat (WB + 1) next_cycle();
`else
    for (int k = 0; k < WB - 1; k++)
      expect_at(k, S_HAZ, 1, "t6_haz");
    expect_at(WB-1, S_HAZ,  '0,          "t6_haz_clear");
    expect_at(WB-1, S_DSEL, 'h80000000,  "t6_dsel_x31");
    expect_at(WB,   S_ASEL, 'h80000000,  "t6_asel");
    repeat (WB) next_cycle();
    idle();
    repeat (2) next_cycle();
`endif

    // Every queued expectation must have come due
    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL sb_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
